// File: rtl/game_pkg.sv
// Shared constants and state encoding for the tic-tac-toe turn/round sequencer.
package game_pkg;

    localparam int unsigned CELLS  = 9;
    localparam int unsigned SLOT_W = 4;

    localparam logic BLUE = 1'b0;
    localparam logic RED  = 1'b1;

    localparam logic [CELLS-1:0] FULL_MASK = {CELLS{1'b1}};

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        SELECT = 3'd1,
        WRITE  = 3'd2,
        CHECK  = 3'd3,
        SWITCH = 3'd4,
        OVER   = 3'd5
    } state_t;

endpackage

// File: rtl/free_cell_finder.sv
// Combinational search of the occupancy vector: lowest free cell, next free
// cell after the cursor (wrapping), and whether any cell is still free.
module free_cell_finder #(
    parameter int unsigned CELLS  = 9,
    parameter int unsigned SLOT_W = 4
) (
    input  logic [CELLS-1:0]  occ,
    input  logic [SLOT_W-1:0] cur_slot,
    output logic [SLOT_W-1:0] first_free,
    output logic [SLOT_W-1:0] next_free,
    output logic              any_free
);

    logic [SLOT_W:0]   idx_wide;
    logic [SLOT_W-1:0] idx;
    logic              found_next;

    always_comb begin
        first_free = '0;
        any_free   = 1'b0;
        for (int i = 0; i < int'(CELLS); i++) begin
            if (!occ[i] && !any_free) begin
                first_free = SLOT_W'(i);
                any_free   = 1'b1;
            end
        end
    end

    // Scan offsets 1..CELLS-1 from the cursor; if nothing else is free the cursor holds.
    always_comb begin
        next_free  = cur_slot;
        found_next = 1'b0;
        idx_wide   = '0;
        idx        = '0;
        for (int k = 1; k < int'(CELLS); k++) begin
            idx_wide = {1'b0, cur_slot} + (SLOT_W+1)'(k);
            if (idx_wide >= (SLOT_W+1)'(CELLS)) begin
                idx_wide = idx_wide - (SLOT_W+1)'(CELLS);
            end
            idx = idx_wide[SLOT_W-1:0];
            if (!found_next && !occ[idx]) begin
                next_free  = idx;
                found_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Turn/round controller: decodes keys into cursor moves and placements, strobes
// board writes, and sequences win/tie/score/new-round.
module game_sequencer #(
    parameter int unsigned CELLS  = game_pkg::CELLS,
    parameter int unsigned SLOT_W = game_pkg::SLOT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_place,
    input  logic              btn_new_round,
    input  logic              btn_clear_score,
    input  logic [CELLS-1:0]  red_board,
    input  logic [CELLS-1:0]  blue_board,
    input  logic              win_in,
    output logic [SLOT_W-1:0] cur_slot,
    output logic              cur_player,
    output logic              we,
    output logic              clear_board,
    output logic              score_blue,
    output logic              score_red,
    output logic              clear_score,
    output logic              round_over,
    output logic              tie,
    output logic              taken
);

    import game_pkg::*;

    state_t            state_q, state_d;
    logic [SLOT_W-1:0] cur_slot_q, cur_slot_d;
    logic              cur_player_q, cur_player_d;
    logic              starter_q, starter_d;
    logic              tie_q, tie_d;
    logic [3:0]        btn_prev_q, btn_prev_d;
    logic              taken_q, taken_d;
    logic              score_blue_q, score_blue_d;
    logic              score_red_q, score_red_d;
    logic              clear_score_q, clear_score_d;

    logic [3:0]        btn_c;
    logic [3:0]        btn_edge_c;
    logic              next_edge_c;
    logic              place_edge_c;
    logic              new_round_edge_c;
    logic              clear_score_edge_c;

    logic [CELLS-1:0]  occ;
    logic [SLOT_W-1:0] first_free;
    logic [SLOT_W-1:0] next_free;
    logic              any_free;

    assign occ = red_board | blue_board;

    free_cell_finder #(
        .CELLS  (CELLS),
        .SLOT_W (SLOT_W)
    ) u_finder (
        .occ        (occ),
        .cur_slot   (cur_slot_q),
        .first_free (first_free),
        .next_free  (next_free),
        .any_free   (any_free)
    );

    // Previous-value registers reset high so a key held through reset never fires.
    assign btn_c              = {btn_clear_score, btn_new_round, btn_place, btn_next};
    assign btn_edge_c         = btn_c & ~btn_prev_q;
    assign next_edge_c        = btn_edge_c[0];
    assign place_edge_c       = btn_edge_c[1];
    assign new_round_edge_c   = btn_edge_c[2];
    assign clear_score_edge_c = btn_edge_c[3];

    always_comb begin
        state_d       = state_q;
        cur_slot_d    = cur_slot_q;
        cur_player_d  = cur_player_q;
        starter_d     = starter_q;
        tie_d         = tie_q;
        btn_prev_d    = btn_c;
        taken_d       = 1'b0;
        score_blue_d  = 1'b0;
        score_red_d   = 1'b0;
        clear_score_d = clear_score_edge_c;

        case (state_q)
            CLEAR: begin
                cur_slot_d   = '0;
                cur_player_d = starter_q;
                tie_d        = 1'b0;
                state_d      = SELECT;
            end
            SELECT: begin
                if (place_edge_c) begin
                    if (occ[cur_slot_q]) begin
                        taken_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end else if (next_edge_c) begin
                    cur_slot_d = next_free;
                end
            end
            WRITE: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (win_in) begin
                    score_red_d  = (cur_player_q == RED);
                    score_blue_d = (cur_player_q == BLUE);
                    state_d      = OVER;
                end else if (!any_free) begin
                    tie_d   = 1'b1;
                    state_d = OVER;
                end else begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                cur_player_d = ~cur_player_q;
                cur_slot_d   = first_free;
                state_d      = SELECT;
            end
            OVER: begin
                if (new_round_edge_c) begin
                    starter_d = ~starter_q;
                    state_d   = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= CLEAR;
            cur_slot_q    <= '0;
            cur_player_q  <= BLUE;
            starter_q     <= BLUE;
            tie_q         <= 1'b0;
            btn_prev_q    <= '1;
            taken_q       <= 1'b0;
            score_blue_q  <= 1'b0;
            score_red_q   <= 1'b0;
            clear_score_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_slot_q    <= cur_slot_d;
            cur_player_q  <= cur_player_d;
            starter_q     <= starter_d;
            tie_q         <= tie_d;
            btn_prev_q    <= btn_prev_d;
            taken_q       <= taken_d;
            score_blue_q  <= score_blue_d;
            score_red_q   <= score_red_d;
            clear_score_q <= clear_score_d;
        end
    end

    // Pulses are squelched while reset is high, including a WRITE cycle caught mid-flight.
    assign we          = (state_q == WRITE) & ~reset;
    assign clear_board = (state_q == CLEAR) & ~reset;
    assign score_blue  = score_blue_q & ~reset;
    assign score_red   = score_red_q & ~reset;
    assign clear_score = clear_score_q & ~reset;
    assign taken       = taken_q & ~reset;
    assign round_over  = (state_q == OVER);
    assign tie         = (state_q == OVER) & tie_q;
    assign cur_slot    = cur_slot_q;
    assign cur_player  = cur_player_q;

endmodule
